// File: rtl/counter_seq_ctrl.sv
// Run controller for a loadable up/down counter: takes commands over valid/ready, loads the
// start value, issues prescaled count-enable steps until the counter equals the limit.
module counter_seq_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             cnt_en,
   output logic             cnt_dir,
   output logic             busy,
   output logic             done,
   output logic [7:0]       run_count
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   localparam logic [1:0] OpSetPrescale = 2'b00;
   localparam logic [1:0] OpSetLimit    = 2'b01;
   localparam logic [1:0] OpStart       = 2'b10;
   localparam logic [1:0] OpStop        = 2'b11;

   localparam int unsigned CopyW = (PRESCALE_W < WIDTH) ? PRESCALE_W : WIDTH;

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [WIDTH-1:0]      limit_q, limit_d;
   logic [WIDTH-1:0]      start_q, start_d;
   logic [7:0]            run_count_q, run_count_d;
   logic                  dir_q, dir_d;

   logic                  accept;
   logic                  tick;
   logic                  load_dir;
   logic [PRESCALE_W-1:0] prescale_op;

   // Low bits of the operand, zero-extended when the prescaler is wider than the data path.
   assign prescale_op = PRESCALE_W'(cmd_data[CopyW-1:0]);

   assign cmd_ready = (state_q != StLoad);
   assign busy      = (state_q == StLoad) || (state_q == StRun);
   assign accept    = cmd_valid && cmd_ready;
   assign tick      = (pre_cnt_q == prescale_q);
   assign load_dir  = (start_q <= limit_q);
   assign run_count = run_count_q;

   always_comb begin
      state_d      = state_q;
      prescale_d   = prescale_q;
      limit_d      = limit_q;
      start_d      = start_q;
      pre_cnt_d    = pre_cnt_q;
      run_count_d  = run_count_q;
      dir_d        = dir_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      cnt_dir      = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         StLoad: begin
            cnt_load     = 1'b1;
            cnt_load_val = start_q;
            cnt_dir      = load_dir;
            dir_d        = load_dir;
            pre_cnt_d    = '0;
            state_d      = StRun;
         end
         StRun: begin
            cnt_dir   = dir_q;
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
            // An accepted START or STOP pre-empts the tick; SET_* commands let it proceed.
            if (tick && !(accept && cmd_op[1])) begin
               if (cnt_val == limit_q) begin
                  done        = 1'b1;
                  run_count_d = run_count_q + 8'd1;
                  state_d     = StIdle;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (accept) begin
         unique case (cmd_op)
            OpSetPrescale: begin
               prescale_d = prescale_op;
               pre_cnt_d  = '0;
            end
            OpSetLimit: limit_d = cmd_data;
            OpStart: begin
               start_d = cmd_data;
               state_d = StLoad;
            end
            OpStop: state_d = StIdle;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         prescale_q  <= '0;
         pre_cnt_q   <= '0;
         limit_q     <= '1;
         start_q     <= '0;
         run_count_q <= '0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prescale_q  <= prescale_d;
         pre_cnt_q   <= pre_cnt_d;
         limit_q     <= limit_d;
         start_q     <= start_d;
         run_count_q <= run_count_d;
         dir_q       <= dir_d;
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural loadable up/down counter attached.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] cnt_val;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_en;
   logic       cnt_dir;
   logic       busy;
   logic       done;
   logic [7:0] run_count;

   logic [7:0] model_cnt = 8'd0;
   int         tests = 0;
   int         fails = 0;

   counter_seq_ctrl #(.WIDTH(8), .PRESCALE_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_data     (cmd_data),
      .cnt_val      (cnt_val),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .cnt_en       (cnt_en),
      .cnt_dir      (cnt_dir),
      .busy         (busy),
      .done         (done),
      .run_count    (run_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cnt_load)    model_cnt <= cnt_load_val;
      else if (cnt_en) model_cnt <= cnt_dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
   end
   assign cnt_val = model_cnt;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   // Starts and ends just after a falling edge; command accepted on the rising edge in between.
   task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      #1;
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL send_cmd_ready: cmd_ready=%0b, required 1 within 10 cycles", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic observe_run(input int max_cyc, output logic [63:0] en_mask,
                              output int done_cyc);
      en_mask  = '0;
      done_cyc = -1;
      for (int k = 0; k < max_cyc; k++) begin
         #1;
         if (cnt_en) en_mask[k] = 1'b1;
         if (done) begin
            done_cyc = k;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic check_load(input string name, input logic [7:0] val, input logic dir);
      #1;
      tests++;
      if (cnt_load !== 1'b1 || cnt_load_val !== val || cnt_dir !== dir || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL %s_load: load=%0b val=%0d dir=%0b ready=%0b, required 1 %0d %0b 0",
                  name, cnt_load, cnt_load_val, cnt_dir, cmd_ready, val, dir);
      end
      @(negedge clk);
   endtask

   task automatic check_run(input string name, input int max_cyc, input logic [63:0] exp_mask,
                            input int exp_done, input logic [7:0] exp_cnt,
                            input logic [7:0] exp_runs);
      logic [63:0] m;
      int          d;
      observe_run(max_cyc, m, d);
      tests++;
      if (m !== exp_mask) begin
         fails++;
         $display("FAIL %s_en_cycles: mask=%h, required %h", name, m, exp_mask);
      end
      tests++;
      if (d !== exp_done) begin
         fails++;
         $display("FAIL %s_done_cycle: got %0d, required %0d", name, d, exp_done);
      end
      #1;
      tests++;
      if (busy !== 1'b0 || model_cnt !== exp_cnt || run_count !== exp_runs) begin
         fails++;
         $display("FAIL %s_end: busy=%0b cnt=%0d runs=%0d, required 0 %0d %0d",
                  name, busy, model_cnt, run_count, exp_cnt, exp_runs);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_load !== 1'b0 || cnt_en !== 1'b0 ||
          done !== 1'b0 || cnt_dir !== 1'b0 || cnt_load_val !== 8'd0 || run_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_outputs: ready=%0b busy=%0b load=%0b en=%0b done=%0b dir=%0b val=%0d runs=%0d, required 1 0 0 0 0 0 0 0",
                  cmd_ready, busy, cnt_load, cnt_en, done, cnt_dir, cnt_load_val, run_count);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_up_run;
      send_cmd(2'b00, 8'd2);
      send_cmd(2'b01, 8'd5);
      send_cmd(2'b10, 8'd2);
      check_load("up", 8'd2, 1'b1);
      check_run("up", 40, 64'h124, 11, 8'd5, 8'd1);
   endtask

   task automatic test_down_run;
      send_cmd(2'b00, 8'd0);
      send_cmd(2'b01, 8'd6);
      send_cmd(2'b10, 8'd9);
      check_load("down", 8'd9, 1'b0);
      check_run("down", 40, 64'h7, 3, 8'd6, 8'd2);
   endtask

   task automatic test_degenerate;
      send_cmd(2'b00, 8'd3);
      send_cmd(2'b01, 8'd7);
      send_cmd(2'b10, 8'd7);
      check_load("degen", 8'd7, 1'b1);
      check_run("degen", 40, 64'h0, 3, 8'd7, 8'd3);
   endtask

   task automatic test_stop;
      int  en_seen = 0;
      bit  done_seen = 1'b0;
      send_cmd(2'b00, 8'd0);
      send_cmd(2'b01, 8'd200);
      send_cmd(2'b10, 8'd0);
      check_load("stop", 8'd0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         #1;
         if (cnt_en) en_seen++;
         @(negedge clk);
      end
      tests++;
      if (en_seen !== 10) begin
         fails++;
         $display("FAIL stop_pre_en: %0d pulses, required 10", en_seen);
      end
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_data  = 8'd0;
      #1;
      tests++;
      if (cnt_en !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL stop_cycle: en=%0b done=%0b ready=%0b, required 0 0 1",
                  cnt_en, done, cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || model_cnt !== 8'd10 || run_count !== 8'd3) begin
         fails++;
         $display("FAIL stop_end: busy=%0b cnt=%0d runs=%0d, required 0 10 3",
                  busy, model_cnt, run_count);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (done || cnt_en) done_seen = 1'b1;
      end
      tests++;
      if (done_seen !== 1'b0) begin
         fails++;
         $display("FAIL stop_idle_quiet: activity=%0b, required 0", done_seen);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      send_cmd(2'b01, 8'd20);
      send_cmd(2'b10, 8'd0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_data  = 8'd50;
      check_load("restart_first", 8'd0, 1'b1);
      #1;
      tests++;
      if (cmd_ready !== 1'b1 || cnt_en !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL restart_accept: ready=%0b en=%0b done=%0b, required 1 0 0",
                  cmd_ready, cnt_en, done);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check_load("restart_second", 8'd50, 1'b0);
      send_cmd(2'b11, 8'd0);
      #1;
      tests++;
      if (busy !== 1'b0 || model_cnt !== 8'd50 || run_count !== 8'd3) begin
         fails++;
         $display("FAIL restart_end: busy=%0b cnt=%0d runs=%0d, required 0 50 3",
                  busy, model_cnt, run_count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      send_cmd(2'b01, 8'd200);
      send_cmd(2'b10, 8'd0);
      check_load("rstrun", 8'd0, 1'b1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL rstrun_no_done: done=%0b, required 0", done);
      end
      @(negedge clk);
      #1;
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_load !== 1'b0 || cnt_en !== 1'b0 ||
          done !== 1'b0 || cnt_dir !== 1'b0 || cnt_load_val !== 8'd0 || run_count !== 8'd0) begin
         fails++;
         $display("FAIL rstrun_outputs: ready=%0b busy=%0b load=%0b en=%0b done=%0b dir=%0b val=%0d runs=%0d, required 1 0 0 0 0 0 0 0",
                  cmd_ready, busy, cnt_load, cnt_en, done, cnt_dir, cnt_load_val, run_count);
      end
      rst = 1'b0;
      @(negedge clk);
      // Limit and prescale are back at 255 and 0: START 250 must step five times then finish.
      send_cmd(2'b10, 8'd250);
      check_load("rstlim", 8'd250, 1'b1);
      check_run("rstlim", 40, 64'h1F, 5, 8'd255, 8'd1);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'd0;
      @(negedge clk);
      test_reset();
      test_up_run();
      test_down_run();
      test_degenerate();
      test_stop();
      test_back_to_back();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
